// File: rtl/aska_fpga_probe.sv
// ---------------------------------------------------------------------------
// aska_fpga_probe
//
// FPGA bring-up harness for aska_dig on the ULX3S board.
//  - Divides the board clock into clk_dut. The half-period terminal count can
//    be reprogrammed at runtime.
//  - Copies a GROUP_W-wide window of the up/down electrode switch buses to the
//    probe header. The window index is stepped manually by grp_next, or
//    automatically at the end of each stimulation pulse.
//  - Counts stimulation pulses with a saturating counter.
//  - Flags any up/down shoot-through with a sticky flag.
//
// Ports
//  clk            board clock (25 MHz)
//  reset          synchronous reset, active high
//  div_value      new half-period terminal count
//  div_load       1-cycle strobe that loads div_value
//  clk_dut        divided clock to aska_dig
//  clk_dut_rise   1-cycle strobe, high in the first cycle that clk_dut is 1
//  mode           0 = manual group select, 1 = auto-scan on pulse end
//  grp_next       manual step request (debounced level; its rising edge is used)
//  up_switches    aska_dig P-switch bus
//  down_switches  aska_dig N-switch bus
//  pulse_active   aska_dig pulse flag
//  clr_stats      1-cycle strobe that clears pulse_count and overlap_err
//  grp_sel        current window index
//  probe_up       registered window of up_switches
//  probe_down     registered window of down_switches
//  pulse_count    pulses seen, saturating
//  overlap_err    sticky shoot-through flag
// ---------------------------------------------------------------------------
module aska_fpga_probe #(
  parameter int ELEC_NUM    = 32,
  parameter int GROUP_W     = 3,
  parameter int DIV_W       = 11,
  parameter int DEFAULT_DIV = 625,
  parameter int CNT_W       = 16,
  localparam int NGRP       = (ELEC_NUM + GROUP_W - 1) / GROUP_W,
  localparam int GSEL_W     = (NGRP > 1) ? $clog2(NGRP) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DIV_W-1:0]    div_value,
  input  logic                div_load,
  output logic                clk_dut,
  output logic                clk_dut_rise,
  input  logic                mode,
  input  logic                grp_next,
  input  logic [ELEC_NUM-1:0] up_switches,
  input  logic [ELEC_NUM-1:0] down_switches,
  input  logic                pulse_active,
  input  logic                clr_stats,
  output logic [GSEL_W-1:0]   grp_sel,
  output logic [GROUP_W-1:0]  probe_up,
  output logic [GROUP_W-1:0]  probe_down,
  output logic [CNT_W-1:0]    pulse_count,
  output logic                overlap_err
);

  // The buses are padded up to a whole number of windows. Bits past
  // ELEC_NUM in the last window read 0.
  localparam int PAD_W = NGRP * GROUP_W;

  logic [DIV_W-1:0]   div_reg;
  logic [DIV_W-1:0]   div_cnt;
  logic [DIV_W-1:0]   load_val;
  logic               p_q;
  logic               g_q;
  logic               pulse_rise;
  logic               pulse_fall;
  logic               grp_rise;
  logic               step_evt;
  logic [PAD_W-1:0]   up_pad;
  logic [PAD_W-1:0]   down_pad;
  logic [GROUP_W-1:0] up_win;
  logic [GROUP_W-1:0] down_win;

  // A terminal count of 0 would make clk_dut toggle every cycle with no
  // count phase, so the smallest value accepted is 1.
  always_comb begin
    load_val = div_value;
    if (div_value == '0) begin
      load_val = DIV_W'(1);
    end
  end

  // Divider. A load restarts the half period from the load edge without
  // toggling, so the clk_dut level seen by aska_dig never glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_reg      <= DIV_W'(DEFAULT_DIV);
      div_cnt      <= '0;
      clk_dut      <= 1'b0;
      clk_dut_rise <= 1'b0;
    end else if (div_load) begin
      div_reg      <= load_val;
      div_cnt      <= '0;
      clk_dut_rise <= 1'b0;
    end else if (div_cnt == div_reg) begin
      div_cnt      <= '0;
      clk_dut      <= ~clk_dut;
      clk_dut_rise <= ~clk_dut;
    end else begin
      div_cnt      <= div_cnt + 1'b1;
      clk_dut_rise <= 1'b0;
    end
  end

  // Edge detection uses the live input against a one-cycle-old copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_q <= 1'b0;
      g_q <= 1'b0;
    end else begin
      p_q <= pulse_active;
      g_q <= grp_next;
    end
  end

  assign pulse_rise = pulse_active & ~p_q;
  assign pulse_fall = ~pulse_active & p_q;
  assign grp_rise   = grp_next & ~g_q;
  assign step_evt   = mode ? pulse_fall : grp_rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      grp_sel <= '0;
    end else if (step_evt) begin
      if (grp_sel == GSEL_W'(NGRP - 1)) begin
        grp_sel <= '0;
      end else begin
        grp_sel <= grp_sel + 1'b1;
      end
    end
  end

  // The window is selected with a mux over constant slices. This keeps
  // every index static, so no part-select can run past the padded bus.
  always_comb begin
    up_pad                   = '0;
    down_pad                 = '0;
    up_pad[ELEC_NUM-1:0]     = up_switches;
    down_pad[ELEC_NUM-1:0]   = down_switches;
    up_win                   = '0;
    down_win                 = '0;
    for (int g = 0; g < NGRP; g++) begin
      if (grp_sel == GSEL_W'(g)) begin
        up_win   = up_pad[g*GROUP_W +: GROUP_W];
        down_win = down_pad[g*GROUP_W +: GROUP_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      probe_up   <= '0;
      probe_down <= '0;
    end else begin
      probe_up   <= up_win;
      probe_down <= down_win;
    end
  end

  // clr_stats wins over a same-cycle increment or overlap.
  always_ff @(posedge clk) begin
    if (reset || clr_stats) begin
      pulse_count <= '0;
      overlap_err <= 1'b0;
    end else begin
      if (pulse_rise && (pulse_count != {CNT_W{1'b1}})) begin
        pulse_count <= pulse_count + 1'b1;
      end
      if (|(up_switches & down_switches)) begin
        overlap_err <= 1'b1;
      end
    end
  end

endmodule
